// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-strobed VGA sync generator with horizontal/vertical interval FSMs.
// Syncs and data-enable are registered from next-state values so they line up with the counters.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          en_i,
  output logic [HW-1:0] hcount_o,
  output logic [VW-1:0] vcount_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic          line_start_o,
  output logic          frame_start_o
);
  typedef enum logic [1:0] {H_ACT, H_FPOR, H_SYN, H_BPOR} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FPOR, V_SYN, V_BPOR} v_state_t;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FP_AT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN_AT = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_BP_AT = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FP_AT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYN_AT = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_BP_AT = VW'(V_ACTIVE + V_FP + V_SYNC);
  h_state_t h_state, h_state_nxt;
  v_state_t v_state, v_state_nxt;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic h_wrap, v_wrap;
  // Later boundaries are tested first so a zero-length interval is skipped cleanly.
  always_comb begin
    h_wrap = hcount_o == H_LAST;
    v_wrap = vcount_o == V_LAST;
    h_nxt = h_wrap ? '0 : hcount_o + HW'(1);
    v_nxt = h_wrap ? (v_wrap ? '0 : vcount_o + VW'(1)) : vcount_o;
    h_state_nxt = h_nxt == H_BP_AT ? H_BPOR :
                  h_nxt == H_SYN_AT ? H_SYN :
                  h_nxt == H_FP_AT ? H_FPOR :
                  h_nxt == '0 ? H_ACT : h_state;
    v_state_nxt = !h_wrap ? v_state :
                  v_nxt == V_BP_AT ? V_BPOR :
                  v_nxt == V_SYN_AT ? V_SYN :
                  v_nxt == V_FP_AT ? V_FPOR :
                  v_nxt == '0 ? V_ACT : v_state;
  end
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      hcount_o <= H_LAST;
      vcount_o <= V_LAST;
      h_state <= H_BPOR;
      v_state <= V_BPOR;
      hsync_o <= !SYNC_POL;
      vsync_o <= !SYNC_POL;
      de_o <= 1'b0;
      line_start_o <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      line_start_o <= en_i && h_wrap;
      frame_start_o <= en_i && h_wrap && v_wrap;
      if (en_i) begin
        hcount_o <= h_nxt;
        vcount_o <= v_nxt;
        h_state <= h_state_nxt;
        v_state <= v_state_nxt;
        hsync_o <= (h_state_nxt == H_SYN) ^ !SYNC_POL;
        vsync_o <= (v_state_nxt == V_SYN) ^ !SYNC_POL;
        de_o <= h_state_nxt == H_ACT && v_state_nxt == V_ACT;
      end
    end
endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, the same four intervals in lines.
REQ-006 SHALL have parameter SYNC_POL, default 0, asserted level of hsync_o/vsync_o.
REQ-007 SHALL derive H_TOTAL = sum of H intervals, V_TOTAL = sum of V intervals, HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL).
REQ-008 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-009 SHALL have port arstn_i, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port en_i, input, 1, pixel-rate strobe (clk_divider strb_o); timing advances only when high.
REQ-011 SHALL have port hcount_o, output, HW, current pixel column.
REQ-012 SHALL have port vcount_o, output, VW, current line.
REQ-013 SHALL have ports hsync_o and vsync_o, output, 1 each, sync pulses at SYNC_POL when asserted.
REQ-014 SHALL have port de_o, output, 1, high when hcount_o < H_ACTIVE and vcount_o < V_ACTIVE.
REQ-015 SHALL have ports line_start_o and frame_start_o, output, 1 each, single-clk pulses.

Function
REQ-016 SHALL run a horizontal FSM with states H_ACT, H_FPOR, H_SYN, H_BPOR in that cyclic order, each lasting its parameter count of en_i strobes.
REQ-017 SHALL run a vertical FSM with states V_ACT, V_FPOR, V_SYN, V_BPOR, advancing one line only on the strobe where hcount_o wraps H_TOTAL-1 -> 0.
REQ-018 SHALL increment hcount_o by 1 on each clk with en_i=1 and wrap H_TOTAL-1 -> 0; SHALL hold all state when en_i=0.
REQ-019 SHALL increment vcount_o on each horizontal wrap and wrap V_TOTAL-1 -> 0 when both counters wrap on the same strobe.
REQ-020 SHALL register hsync_o, vsync_o and de_o from next-state counter values so they change on the same clk edge as the counters (zero skew, 1-clk latency from en_i).
REQ-021 SHALL assert hsync_o while H_ACTIVE+H_FP <= hcount_o < H_ACTIVE+H_FP+H_SYNC; vsync_o likewise on vcount_o for the full lines.
REQ-022 SHALL pulse line_start_o for exactly one clk on the edge where hcount_o becomes 0, and frame_start_o on the edge where both counters become 0.
REQ-023 SHALL keep pulses at one clk even if en_i is held high continuously (DIVISOR = 1).
REQ-024 SHALL treat counters as unsigned, never exceeding H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-025 SHALL, on arstn_i low, immediately set hcount_o = H_TOTAL-1, vcount_o = V_TOTAL-1, hsync_o = vsync_o = !SYNC_POL, de_o = 0, line_start_o = frame_start_o = 0, FSMs to H_BPOR/V_BPOR.
REQ-026 SHALL make the first en_i strobe after reset release produce (0,0), de_o = 1, frame_start_o = line_start_o = 1.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame with no residual pulse after release.

Verification
REQ-028 SHALL cover: params H 4/1/2/1, V 3/1/1/1, en_i tied high -> hcount_o 0..7 repeat, hsync_o asserted at h=5,6, de_o high at h=0..3 on v=0..2, frame period 48 clks.
REQ-029 SHALL cover: same params, en_i = clk_divider DIVISOR 3 -> each count held exactly 3 clks, frame period 144 clks, pulses still 1 clk.
REQ-030 SHALL cover: default params, en_i high -> vsync_o asserted exactly for v=490,491, frame period 420000 clks.
REQ-031 SHALL cover: reset release, en_i low 10 clks -> outputs hold reset values; first strobe -> (0,0), frame_start_o one pulse.
REQ-032 SHALL cover: arstn_i low at (h=5,v=1) mid-line -> next clk (7,5) values, de_o = 0, no stale line_start_o.
REQ-033 SHALL cover: SYNC_POL = 1 -> hsync_o/vsync_o inverted, all other outputs identical to SYNC_POL = 0 run.
